// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared arbiter states, sizes and one-hot helper
package calc_pkg;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - rotate-priority pick of the first request at or after ptr
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] cand;

  // Scan from farthest to nearest so the nearest set bit overwrites last
  always_comb begin
    idx  = ptr;
    any  = 1'b0;
    cand = '0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// rtl/result_bus_arbiter.sv - round-robin owner of the shared 4-to-1 result mux
import calc_pkg::*;

module result_bus_arbiter #(
  parameter int NREQ  = calc_pkg::NREQ,
  parameter int WIDTH = calc_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             res_ready,
  output logic [NREQ-1:0]  sel,
  output logic             res_valid,
  output logic [NREQ-1:0]  ack,
  input  logic [WIDTH-1:0] mux_out
);

  state_t     state, state_nx;
  logic [1:0] rr_ptr, rr_ptr_nx;
  logic [1:0] winner, winner_nx;
  logic [1:0] pick_idx;
  logic       pick_any;
  logic       unused_mux;

  assign unused_mux = ^mux_out;

  rr_pick4 u_pick (
    .req (req),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      winner <= '0;
    end else begin
      state  <= state_nx;
      rr_ptr <= rr_ptr_nx;
      winner <= winner_nx;
    end
  end

  // Outputs decode from registered state only, so reset clears them at once
  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    winner_nx = winner;
    sel       = '0;
    res_valid = 1'b0;
    ack       = '0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          winner_nx = pick_idx;
          state_nx  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        res_valid = 1'b1;
        sel       = onehot4(winner);
        if (res_ready) begin
          ack       = onehot4(winner);
          rr_ptr_nx = winner + 2'd1;
          state_nx  = ST_IDLE;
        end else if (!req[winner]) begin
          state_nx  = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// tb/tb_result_bus_arbiter.sv - randomized and directed bench against a transaction model
module tb_result_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic        res_ready = 1'b0;
  logic [3:0]  sel;
  logic        res_valid;
  logic [3:0]  ack;
  logic [15:0] mux_out = 16'h0000;

  int n_pass = 0;
  int n_total = 0;

  // Model: who holds the bus (if anyone) and where the next scan begins
  bit m_busy = 1'b0;
  int m_win = 0;
  int m_ptr = 0;

  result_bus_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .res_ready (res_ready),
    .sel       (sel),
    .res_valid (res_valid),
    .ack       (ack),
    .mux_out   (mux_out)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int p);
    int c;
    pick = -1;
    for (int k = 0; k < 4; k++) begin
      c = (p + k) % 4;
      if (r[c] && pick < 0) pick = c;
    end
  endfunction

  function automatic logic [3:0] exp_sel();
    return m_busy ? 4'(1 << m_win) : 4'b0000;
  endfunction

  function automatic logic [3:0] exp_ack();
    return (m_busy && res_ready) ? 4'(1 << m_win) : 4'b0000;
  endfunction

  function automatic bit onehot0(input logic [3:0] v);
    return (v & (v - 4'd1)) == 4'd0;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_win  = 0;
    m_ptr  = 0;
  endtask

  task automatic tick();
    int w;
    if (!m_busy) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin
        m_busy = 1'b1;
        m_win  = w;
      end
    end else if (res_ready) begin
      m_ptr  = (m_win + 1) % 4;
      m_busy = 1'b0;
    end else if (!req[m_win]) begin
      m_busy = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0000;
    res_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    res_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (sel !== 4'b0000) $display("FAIL reset_sel got=%b want=0000", sel); else n_pass++;
    n_total++;
    if (res_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", res_valid); else n_pass++;
    n_total++;
    if (ack !== 4'b0000) $display("FAIL reset_ack got=%b want=0000", ack); else n_pass++;
    rst_n = 1'b1;
    req = 4'b0001;
    res_ready = 1'b0;
    tick();
    n_total++;
    if (sel !== 4'b0001 || res_valid !== 1'b1)
      $display("FAIL reset_first_grant got sel=%b valid=%b want sel=0001 valid=1", sel, res_valid);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [9];
    seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    req = 4'b1111;
    res_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_total++;
      if (sel !== seq[i] || sel !== exp_sel())
        $display("FAIL rr_sel[%0d] got=%b want=%b", i, sel, seq[i]);
      else n_pass++;
      n_total++;
      if (ack !== seq[i])
        $display("FAIL rr_ack[%0d] got=%b want=%b", i, ack, seq[i]);
      else n_pass++;
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_back_pressure();
    do_reset();
    req = 4'b0100;
    res_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (sel !== 4'b0100 || res_valid !== 1'b1 || ack !== 4'b0000)
        $display("FAIL bp_hold[%0d] got sel=%b valid=%b ack=%b want 0100/1/0000", i, sel, res_valid, ack);
      else n_pass++;
      tick();
    end
    res_ready = 1'b1;
    #1;
    n_total++;
    if (ack !== 4'b0100) $display("FAIL bp_ack got=%b want=0100", ack); else n_pass++;
    req = 4'b0000;
    tick();
    n_total++;
    if (sel !== 4'b0000 || res_valid !== 1'b0)
      $display("FAIL bp_release got sel=%b valid=%b want 0000/0", sel, res_valid);
    else n_pass++;
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 4'b0001;
    res_ready = 1'b1;
    tick();
    tick();
    req = 4'b0010;
    res_ready = 1'b0;
    tick();
    n_total++;
    if (sel !== 4'b0010) $display("FAIL wd_grant got=%b want=0010", sel); else n_pass++;
    req = 4'b0000;
    #1;
    n_total++;
    if (ack !== 4'b0000) $display("FAIL wd_no_ack got=%b want=0000", ack); else n_pass++;
    tick();
    n_total++;
    if (sel !== 4'b0000 || res_valid !== 1'b0)
      $display("FAIL wd_abort got sel=%b valid=%b want 0000/0", sel, res_valid);
    else n_pass++;
    req = 4'b0011;
    tick();
    n_total++;
    if (sel !== 4'b0010 || sel !== exp_sel())
      $display("FAIL wd_ptr_kept got=%b want=0010", sel);
    else n_pass++;
    // Withdraw and ready together: the transfer still completes
    req = 4'b0001;
    res_ready = 1'b1;
    #1;
    n_total++;
    if (ack !== 4'b0010) $display("FAIL wd_ready_wins got=%b want=0010", ack); else n_pass++;
    tick();
    req = 4'b0000;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0100;
    res_ready = 1'b1;
    tick();
    tick();
    req = 4'b0101;
    tick();
    n_total++;
    if (sel !== 4'b0001) $display("FAIL wrap_first got=%b want=0001", sel); else n_pass++;
    tick();
    tick();
    n_total++;
    if (sel !== 4'b0100) $display("FAIL wrap_second got=%b want=0100", sel); else n_pass++;
    req = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b1000;
    res_ready = 1'b0;
    tick();
    n_total++;
    if (sel !== 4'b1000) $display("FAIL ar_grant got=%b want=1000", sel); else n_pass++;
    #2;
    res_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (sel !== 4'b0000 || res_valid !== 1'b0 || ack !== 4'b0000)
      $display("FAIL ar_drop got sel=%b valid=%b ack=%b want 0000/0/0000", sel, res_valid, ack);
    else n_pass++;
    #1;
    rst_n = 1'b1;
    req = 4'b1111;
    res_ready = 1'b0;
    tick();
    n_total++;
    if (sel !== 4'b0001) $display("FAIL ar_restart got=%b want=0001", sel); else n_pass++;
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req = 4'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (ack !== exp_ack() || !onehot0(ack) || (ack != 0 && !res_valid)) begin
        if (bad < 5) $display("FAIL rand_ack[%0d] got=%b want=%b", i, ack, exp_ack());
        bad++;
      end
      tick();
      if (sel !== exp_sel() || res_valid !== m_busy || !onehot0(sel) || (res_valid && sel == 0)) begin
        if (bad < 5) $display("FAIL rand_sel[%0d] got sel=%b valid=%b want sel=%b valid=%b",
                              i, sel, res_valid, exp_sel(), m_busy);
        bad++;
      end
    end
    n_total++;
    if (bad != 0) $display("FAIL rand_total errors=%0d want=0", bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_withdraw();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
